// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO register core: register indices and control bit layout.
package gpio_pkg;
  localparam int GPIO_W_DEF = 32;

  localparam logic [3:0] RGPIO_IN    = 4'h0;
  localparam logic [3:0] RGPIO_OUT   = 4'h1;
  localparam logic [3:0] RGPIO_OE    = 4'h2;
  localparam logic [3:0] RGPIO_INTE  = 4'h3;
  localparam logic [3:0] RGPIO_PTRIG = 4'h4;
  localparam logic [3:0] RGPIO_INTS  = 4'h5;
  localparam logic [3:0] RGPIO_CTRL  = 4'h6;

  localparam int CTRL_INTE = 0;
endpackage

// File: rtl/gpio_sync.sv
// Two-flop input synchroniser plus a history flop for edge detection.
module gpio_sync #(
  parameter int W = 32
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  input  logic [W-1:0] d,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/gpio_core.sv
// GPIO register file, edge-triggered interrupt status and level IRQ output.
module gpio_core
  import gpio_pkg::*;
#(
  parameter int GPIO_W = GPIO_W_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              gpio_we,
  input  logic [3:0]        gpio_addr,
  input  logic [31:0]       gpio_dat_i,
  output logic [31:0]       gpio_dat_o,
  output logic              gpio_inta_o,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe
);
  logic [GPIO_W-1:0] sync, rise, fall;
  logic [GPIO_W-1:0] inte, ptrig, ints;
  logic [GPIO_W-1:0] wdat, w1c, ev;
  logic              ctrl_inte;

  gpio_sync #(.W(GPIO_W)) u_sync (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .d       (gpio_in),
    .sync    (sync),
    .rise    (rise),
    .fall    (fall)
  );

  assign wdat = gpio_dat_i[GPIO_W-1:0];
  assign w1c  = (gpio_we && gpio_addr == RGPIO_INTS) ? wdat : '0;
  assign ev   = inte & ((ptrig & rise) | (~ptrig & fall));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      gpio_out    <= '0;
      gpio_oe     <= '0;
      inte        <= '0;
      ptrig       <= '0;
      ints        <= '0;
      ctrl_inte   <= 1'b0;
      gpio_inta_o <= 1'b0;
    end else begin
      if (gpio_we) begin
        case (gpio_addr)
          RGPIO_OUT:   gpio_out  <= wdat;
          RGPIO_OE:    gpio_oe   <= wdat;
          RGPIO_INTE:  inte      <= wdat;
          RGPIO_PTRIG: ptrig     <= wdat;
          RGPIO_CTRL:  ctrl_inte <= gpio_dat_i[CTRL_INTE];
          default: ;
        endcase
      end
      // A new event wins over a same-cycle clear of that bit
      ints        <= (ints & ~w1c) | ev;
      gpio_inta_o <= ctrl_inte & |(ints & inte);
    end
  end

  always_comb begin
    gpio_dat_o = '0;
    case (gpio_addr)
      RGPIO_IN:    gpio_dat_o[GPIO_W-1:0] = sync;
      RGPIO_OUT:   gpio_dat_o[GPIO_W-1:0] = gpio_out;
      RGPIO_OE:    gpio_dat_o[GPIO_W-1:0] = gpio_oe;
      RGPIO_INTE:  gpio_dat_o[GPIO_W-1:0] = inte;
      RGPIO_PTRIG: gpio_dat_o[GPIO_W-1:0] = ptrig;
      RGPIO_INTS:  gpio_dat_o[GPIO_W-1:0] = ints;
      RGPIO_CTRL:  gpio_dat_o[CTRL_INTE]  = ctrl_inte;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_gpio_core.sv
// Directed bench for gpio_core; expectations are queued and compared by a separate monitor.
module tb_gpio_core;
  logic        PCLK, PRESETn;
  logic        gpio_we;
  logic [3:0]  gpio_addr;
  logic [31:0] gpio_dat_i, gpio_dat_o;
  logic        gpio_inta_o;
  logic [31:0] gpio_in, gpio_out, gpio_oe;

  gpio_core #(.GPIO_W(32)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .gpio_we     (gpio_we),
    .gpio_addr   (gpio_addr),
    .gpio_dat_i  (gpio_dat_i),
    .gpio_dat_o  (gpio_dat_o),
    .gpio_inta_o (gpio_inta_o),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe)
  );

  initial PCLK = 1'b0;
  always #50 PCLK = ~PCLK;

  // kind: 0 = read data, 1 = gpio_out, 2 = gpio_oe, 3 = interrupt line
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  logic  chk_stb = 1'b0;
  int    checks  = 0;
  int    errors  = 0;

  always @(posedge chk_stb) begin
    item_t       it;
    logic [31:0] act;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got strobe with no expected entry");
    end else begin
      it = sb.pop_front();
      case (it.kind)
        0:       act = gpio_dat_o;
        1:       act = gpio_out;
        2:       act = gpio_oe;
        default: act = {31'b0, gpio_inta_o};
      endcase
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input int kind, input logic [3:0] a, input logic [31:0] e, input string n);
    item_t it;
    gpio_addr = a;
    #1;
    it.kind = kind;
    it.exp  = e;
    it.name = n;
    sb.push_back(it);
    chk_stb = 1'b1;
    #1 chk_stb = 1'b0;
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
    chk(0, a, e, n);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    gpio_we    = 1'b1;
    gpio_addr  = a;
    gpio_dat_i = d;
    cyc();
    gpio_we    = 1'b0;
  endtask

  initial begin
    PRESETn    = 1'b0;
    gpio_we    = 1'b0;
    gpio_addr  = '0;
    gpio_dat_i = '0;
    gpio_in    = '0;
    repeat (3) cyc();
    PRESETn = 1'b1;

    // reset state
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0, $sformatf("reset_rd_%0h", i));
    chk(1, 4'h0, 32'h0, "reset_out");
    chk(2, 4'h0, 32'h0, "reset_oe");
    chk(3, 4'h0, 32'h0, "reset_inta");

    // output registers and unmapped/RO addresses
    wr(4'h1, 32'hA5A5_5A5A);
    chk(1, 4'h1, 32'hA5A5_5A5A, "out_pin");
    chk(2, 4'h1, 32'h0, "oe_before_wr");
    wr(4'h2, 32'hFFFF_0000);
    chk(2, 4'h2, 32'hFFFF_0000, "oe_pin");
    rd(4'h1, 32'hA5A5_5A5A, "out_rd");
    rd(4'h2, 32'hFFFF_0000, "oe_rd");
    wr(4'h9, 32'hFFFF_FFFF);
    rd(4'h9, 32'h0, "unmapped_rd");
    wr(4'h0, 32'hFFFF_FFFF);
    rd(4'h0, 32'h0, "in_ro");
    wr(4'h6, 32'hFFFF_FFFF);
    rd(4'h6, 32'h1, "ctrl_mask");

    // rising edge on pin 3: latency chain
    wr(4'h3, 32'h8);
    wr(4'h4, 32'h8);
    wr(4'h6, 32'h1);
    gpio_in = 32'h8;
    cyc();
    rd(4'h0, 32'h0, "in_k");
    cyc();
    rd(4'h0, 32'h8, "in_k1");
    rd(4'h5, 32'h0, "ints_k1");
    cyc();
    rd(4'h5, 32'h8, "ints_k2");
    chk(3, 4'h5, 32'h0, "inta_k2");
    cyc();
    chk(3, 4'h5, 32'h1, "inta_k3");

    // falling edges: ignored with PTRIG=1, caught with PTRIG=0
    gpio_in = 32'h20;
    repeat (4) cyc();
    rd(4'h5, 32'h8, "ints_fall_ptrig1");
    wr(4'h4, 32'h0);
    wr(4'h3, 32'h28);
    rd(4'h5, 32'h8, "ints_ptrig_change");
    gpio_in = 32'h0;
    repeat (3) cyc();
    rd(4'h5, 32'h28, "ints_fall_pin5");

    // clear all; IRQ drops one cycle later
    wr(4'h5, 32'hFFFF_FFFF);
    rd(4'h5, 32'h0, "ints_w1c_all");
    chk(3, 4'h5, 32'h1, "inta_clr_k");
    cyc();
    chk(3, 4'h5, 32'h0, "inta_clr_k1");

    // set beats same-cycle W1C
    wr(4'h3, 32'h8);
    wr(4'h4, 32'h8);
    gpio_in = 32'h8;
    repeat (3) cyc();
    rd(4'h5, 32'h8, "ints_rise_again");
    gpio_in = 32'h0;
    repeat (3) cyc();
    rd(4'h5, 32'h8, "ints_fall_ignored");
    gpio_in = 32'h8;
    cyc();
    cyc();
    wr(4'h5, 32'h8);
    rd(4'h5, 32'h8, "ints_set_priority");
    wr(4'h5, 32'h8);
    rd(4'h5, 32'h0, "ints_plain_w1c");
    chk(3, 4'h5, 32'h1, "inta_w1c_k");
    cyc();
    chk(3, 4'h5, 32'h0, "inta_w1c_k1");

    // pending interrupt, then reset mid-write with pins all high
    wr(4'h3, 32'hFFFF_FFFF);
    wr(4'h4, 32'hFFFF_FFFF);
    gpio_in = 32'hFFFF_FFFF;
    repeat (4) cyc();
    rd(4'h5, 32'hFFFF_FFF7, "ints_all_rise");
    chk(3, 4'h5, 32'h1, "inta_pending");
    gpio_we    = 1'b1;
    gpio_addr  = 4'h1;
    gpio_dat_i = 32'h1234_5678;
    #1 PRESETn = 1'b0;
    cyc();
    cyc();
    gpio_we = 1'b0;
    PRESETn = 1'b1;
    for (int i = 0; i < 7; i++) rd(4'(i), 32'h0, $sformatf("rst2_rd_%0h", i));
    chk(1, 4'h0, 32'h0, "rst2_out");
    chk(2, 4'h0, 32'h0, "rst2_oe");
    chk(3, 4'h0, 32'h0, "rst2_inta");
    repeat (4) cyc();
    rd(4'h0, 32'hFFFF_FFFF, "rst2_in_sync");
    rd(4'h5, 32'h0, "rst2_no_ints");
    chk(3, 4'h5, 32'h0, "rst2_no_inta");
    wr(4'h3, 32'hFFFF_FFFF);
    wr(4'h6, 32'h1);
    cyc();
    rd(4'h5, 32'h0, "rst2_inte_settled");
    chk(3, 4'h5, 32'h0, "rst2_inta_settled");

    #5;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
